updw_monitor: RTL and testbench

- Downstream checker for the 3-bit triangle up/down counter stream: 0,1,…,7,6,…,1,0,1,…
- Samples the count on a valid strobe and locks onto the sequence direction.
- Flags every sample that breaks the ±1/turnaround rule, and counts completed periods plus peaks and troughs.
- Used in lab builds to drive status LEDs and to self-check the counter on the board.

---
 rtl/updw_pkg.sv | 7 +
 rtl/updw_next_expect.sv | 17 +
 rtl/updw_monitor.sv | 98 +++++++++
 tb/tb_updw_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/updw_pkg.sv
// updw_pkg: shared state encoding and count limits for the up/down counter monitor
package updw_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_LOCKED} state_t;
  localparam int COUNT_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 3'd7;
  localparam logic [COUNT_W-1:0] COUNT_MIN = 3'd0;
endpackage

// File: rtl/updw_next_expect.sv
// updw_next_expect: predicts the next triangle-counter value and direction
// last: previously accepted sample; dir: current direction (1=up)
// expected: value the next sample must carry; next_dir: direction after accepting it
module updw_next_expect
  import updw_pkg::*;
(
  input  logic [COUNT_W-1:0] last,
  input  logic               dir,
  output logic [COUNT_W-1:0] expected,
  output logic               next_dir
);
  always_comb begin
    expected = dir ? (last == COUNT_MAX ? last - 3'd1 : last + 3'd1)
                   : (last == COUNT_MIN ? last + 3'd1 : last - 3'd1);
    next_dir = dir ? last != COUNT_MAX : last == COUNT_MIN;
  end
endmodule

// File: rtl/updw_monitor.sv
// updw_monitor: locks onto a 3-bit triangle count stream and flags/counts deviations
// in:  clk, reset_n (async, active-low), valid, count_in, clear (sync, counters/error only)
// out: locked, dir, error (sticky), err_count (saturating), period_count (wrapping),
//      peak/trough (one-cycle pulses on accepted 7/0 while locked)
module updw_monitor
  import updw_pkg::*;
#(
  parameter int PERIOD_W = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid,
  input  logic [COUNT_W-1:0]  count_in,
  input  logic                clear,
  output logic                locked,
  output logic                dir,
  output logic                error,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [PERIOD_W-1:0] period_count,
  output logic                peak,
  output logic                trough
);
  state_t state, state_d;
  logic [COUNT_W-1:0] last, last_d, expected;
  logic next_dir, dir_d, locked_d, error_d, peak_d, trough_d;
  logic [ERRCNT_W-1:0] err_d;
  logic [PERIOD_W-1:0] per_d;
  updw_next_expect u_next (.last, .dir, .expected, .next_dir);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= S_IDLE;
      last         <= '0;
      dir          <= 1'b0;
      locked       <= 1'b0;
      error        <= 1'b0;
      err_count    <= '0;
      period_count <= '0;
      peak         <= 1'b0;
      trough       <= 1'b0;
    end else begin
      state        <= state_d;
      last         <= last_d;
      dir          <= dir_d;
      locked       <= locked_d;
      error        <= error_d;
      err_count    <= err_d;
      period_count <= per_d;
      peak         <= peak_d;
      trough       <= trough_d;
    end
  always_comb begin
    state_d  = state;
    last_d   = last;
    dir_d    = dir;
    locked_d = locked;
    error_d  = error;
    err_d    = err_count;
    per_d    = period_count;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    if (valid) begin
      last_d = count_in;
      case (state)
        S_IDLE: state_d = S_FIRST;
        S_FIRST:
          if (count_in == last + 3'd1 && last != COUNT_MAX) begin
            dir_d    = 1'b1;
            locked_d = 1'b1;
            state_d  = S_LOCKED;
          end else if (count_in == last - 3'd1 && last != COUNT_MIN) begin
            dir_d    = 1'b0;
            locked_d = 1'b1;
            state_d  = S_LOCKED;
          end
        S_LOCKED:
          if (count_in == expected) begin
            dir_d    = next_dir;
            peak_d   = count_in == COUNT_MAX;
            trough_d = count_in == COUNT_MIN;
            per_d    = count_in == COUNT_MIN ? period_count + 1'b1 : period_count;
          end else begin
            error_d  = 1'b1;
            err_d    = &err_count ? err_count : err_count + 1'b1;
            locked_d = 1'b0;
            state_d  = S_FIRST;
          end
        default: state_d = S_IDLE;
      endcase
    end
    // clear overrides any same-cycle mismatch or trough update
    if (clear) begin
      error_d = 1'b0;
      err_d   = '0;
      per_d   = '0;
    end
  end
endmodule

// File: tb/tb_updw_monitor.sv
// tb_updw_monitor: directed self-checking bench for updw_monitor
module tb_updw_monitor;
  logic clk = 1'b0, reset_n = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [2:0] count_in = 3'd0;
  logic locked, dir, error, peak, trough;
  logic [7:0] err_count, period_count;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  updw_monitor #(.PERIOD_W(8), .ERRCNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .count_in(count_in), .clear(clear),
    .locked(locked), .dir(dir), .error(error), .err_count(err_count),
    .period_count(period_count), .peak(peak), .trough(trough)
  );

  function automatic logic [4:0] flags();
    return {locked, dir, error, peak, trough};
  endfunction

  function automatic logic [2:0] tri_val(input int i);
    int m;
    m = i % 14;
    return (m <= 7) ? 3'(m) : 3'(14 - m);
  endfunction

  task automatic step(input logic v, input logic [2:0] c, input logic clr);
    @(negedge clk);
    valid = v;
    count_in = c;
    clear = clr;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++;
    if ({flags(), err_count, period_count} !== 21'd0) begin
      bad++;
      $display("FAIL reset_state got=%b/%0d/%0d exp=0/0/0", flags(), err_count, period_count);
    end
    do_reset();
  endtask

  task automatic test_stream(input bit gap);
    logic [2:0] v;
    logic de;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      v = tri_val(i);
      de = (i >= 1) && (i % 14 >= 1) && (i % 14 <= 7);
      step(1'b1, v, 1'b0);
      total++;
      if (flags() !== {i >= 1, de, 1'b0, i >= 1 && v == 3'd7, i >= 1 && v == 3'd0}) begin
        bad++;
        $display("FAIL stream%0d_flags i=%0d got=%b exp=%b", gap, i, flags(),
                 {i >= 1, de, 1'b0, i >= 1 && v == 3'd7, i >= 1 && v == 3'd0});
      end
      total++;
      if ({err_count, period_count} !== {8'd0, 8'(i / 14)}) begin
        bad++;
        $display("FAIL stream%0d_counts i=%0d got=%0d/%0d exp=0/%0d", gap, i, err_count, period_count, i / 14);
      end
      if (gap) begin
        step(1'b0, 3'd5, 1'b0);
        total++;
        if ({flags(), period_count} !== {i >= 1, de, 3'b000, 8'(i / 14)}) begin
          bad++;
          $display("FAIL gap_hold i=%0d got=%b/%0d exp=%b/%0d", i, flags(), period_count,
                   {i >= 1, de, 3'b000}, i / 14);
        end
      end
    end
    step(1'b0, 3'd0, 1'b1);
    total++;
    if ({locked, dir, period_count} !== {2'b11, 8'd0}) begin
      bad++;
      $display("FAIL clear_period got=%b%b/%0d exp=11/0", locked, dir, period_count);
    end
  endtask

  task automatic test_jump();
    do_reset();
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    total++;
    if ({flags(), err_count} !== {5'b01100, 8'd1}) begin
      bad++;
      $display("FAIL jump_mismatch got=%b/%0d exp=01100/1", flags(), err_count);
    end
    step(1'b1, 3'd6, 1'b0);
    total++;
    if (flags() !== 5'b11100) begin
      bad++;
      $display("FAIL jump_relock got=%b exp=11100", flags());
    end
    step(1'b1, 3'd7, 1'b0);
    total++;
    if ({flags(), err_count} !== {5'b11110, 8'd1}) begin
      bad++;
      $display("FAIL jump_peak got=%b/%0d exp=11110/1", flags(), err_count);
    end
  endtask

  task automatic test_midstream();
    do_reset();
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    total++;
    if ({flags(), err_count} !== {5'b10000, 8'd0}) begin
      bad++;
      $display("FAIL mid_down_lock got=%b/%0d exp=10000/0", flags(), err_count);
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd3, 1'b0);
      total++;
      if ({flags(), err_count} !== {5'b00000, 8'd0}) begin
        bad++;
        $display("FAIL repeat_no_lock k=%0d got=%b/%0d exp=00000/0", k, flags(), err_count);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    for (int k = 0; k < 300; k++) begin
      step(1'b1, k[0] ? 3'd1 : 3'd4, 1'b0);
      step(1'b1, k[0] ? 3'd2 : 3'd5, 1'b0);
    end
    total++;
    if ({locked, error, err_count} !== {2'b11, 8'd255}) begin
      bad++;
      $display("FAIL err_saturate got=%b%b/%0d exp=11/255", locked, error, err_count);
    end
  endtask

  task automatic test_reset_clear();
    do_reset();
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    total++;
    if ({flags(), err_count} !== {5'b11100, 8'd3}) begin
      bad++;
      $display("FAIL pre_reset got=%b/%0d exp=11100/3", flags(), err_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({flags(), err_count, period_count} !== 21'd0) begin
      bad++;
      $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0", flags(), err_count, period_count);
    end
    #1;
    reset_n = 1'b1;
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    total++;
    if ({flags(), err_count} !== {5'b11100, 8'd1}) begin
      bad++;
      $display("FAIL pre_clear got=%b/%0d exp=11100/1", flags(), err_count);
    end
    step(1'b1, 3'd1, 1'b1);
    total++;
    if ({flags(), err_count} !== {5'b01000, 8'd0}) begin
      bad++;
      $display("FAIL clear_wins got=%b/%0d exp=01000/0", flags(), err_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_jump();
    test_stream(1'b1);
    test_midstream();
    test_saturate();
    test_reset_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
